// File: rtl/mau_pkg.sv
// Shared encodings for the data-memory load/store unit.
// Build option MAU_ERR_COUNT_EN is consumed by mem_access_unit.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  // Bit i of a lane mask selects data[8*i +: 8]; big-endian, so offset 0 is lane 3.
  localparam logic [NUM_LANES-1:0] LANE_BYTE0   = 4'b1000;
  localparam logic [NUM_LANES-1:0] LANE_HALF_HI = 4'b1100;
  localparam logic [NUM_LANES-1:0] LANE_HALF_LO = 4'b0011;
  localparam logic [NUM_LANES-1:0] LANE_WORD    = 4'b1111;

  typedef enum logic [2:0] {IDLE, RD, WR, ERR, RSP} mau_state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] wdata;
  } mau_req_t;

  function automatic logic [NUM_LANES-1:0] lane_sel(input logic [1:0] size,
                                                    input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_sel = LANE_BYTE0 >> off;
      SZ_HALF: lane_sel = off[1] ? LANE_HALF_LO : LANE_HALF_HI;
      SZ_WORD: lane_sel = LANE_WORD;
      default: lane_sel = '0;
    endcase
  endfunction

  function automatic logic align_err(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: align_err = 1'b0;
      SZ_HALF: align_err = off[0];
      SZ_WORD: align_err = |off;
      default: align_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response handshake plus the active-low data-RAM bus.
// master = the load/store unit, slave = its environment (CPU datapath + RAM).
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWriteData;
  logic              mem_nRD;
  logic              mem_nWR;
  logic [31:0]       MemDataIn;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, MemDataIn,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, MemAddr, MemWriteData, mem_nRD, mem_nWR
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, MemDataIn,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, MemAddr, MemWriteData, mem_nRD, mem_nWR
  );
endinterface

// File: rtl/mau_lane_align.sv
// Combinational big-endian lane logic: load extraction/extension and
// sub-word store merge into the word read back from RAM.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [NUM_LANES-1:0]             sel;
  logic [NUM_LANES-1:0][LANE_W-1:0] rlane;
  logic [NUM_LANES-1:0][LANE_W-1:0] wrep;
  logic [NUM_LANES-1:0][LANE_W-1:0] mlane;
  logic [7:0]                       byte_v;
  logic [15:0]                      half_v;

  assign sel   = lane_sel(size_i, off_i);
  assign rlane = rword_i;

  // Replicate store data so every candidate lane already holds the right bytes.
  always_comb begin
    wrep = wdata_i;
    case (size_i)
      SZ_BYTE: wrep = {NUM_LANES{wdata_i[7:0]}};
      SZ_HALF: wrep = {2{wdata_i[15:0]}};
      default: wrep = wdata_i;
    endcase
  end

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign mlane[i] = sel[i] ? wrep[i] : rlane[i];
    end
  endgenerate

  assign merge_o = mlane;

  assign byte_v = rlane[~off_i];
  assign half_v = off_i[1] ? rword_i[15:0] : rword_i[31:16];

  always_comb begin
    load_o = '0;
    case (size_i)
      SZ_BYTE: load_o = {{24{sgn_i & byte_v[7]}}, byte_v};
      SZ_HALF: load_o = {{16{sgn_i & half_v[15]}}, half_v};
      SZ_WORD: load_o = rword_i;
      default: load_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the active-low, big-endian data RAM bus.
// Define MAU_ERR_COUNT_EN to add the saturating err_count[15:0] output.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  mem_access_unit_if.master  bus
`ifdef MAU_ERR_COUNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  mau_state_e        state_q, state_d;
  mau_req_t          req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              nrd_q, nrd_d;
  logic              nwr_q, nwr_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   last_byte;
  logic              acc_err;
  logic [31:0]       load_w;
  logic [31:0]       merge_w;

  assign base      = {bus.req_addr[ADDR_W-1:2], 2'b00};
  assign last_byte = {1'b0, base} + (ADDR_W+1)'(3);
  assign acc_err   = align_err(bus.req_size, bus.req_addr[1:0]) ||
                     (last_byte >= (ADDR_W+1)'(MEM_BYTES));

  // Fed straight from MemDataIn so the read word is consumed at the end of RD.
  mau_lane_align u_align (
    .off_i   (req_q.off),
    .size_i  (req_q.size),
    .sgn_i   (req_q.sgn),
    .rword_i (bus.MemDataIn),
    .wdata_i (req_q.wdata),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    nrd_d   = 1'b1;
    nwr_d   = 1'b1;
    vld_d   = 1'b0;
    rdat_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        req_d = '{write: bus.req_write, size: bus.req_size, sgn: bus.req_signed,
                  off: bus.req_addr[1:0], wdata: bus.req_wdata};
        if (acc_err) begin
          state_d = ERR;
        end else begin
          addr_d = base;
          if (bus.req_write && bus.req_size == SZ_WORD) begin
            state_d = WR;
            nwr_d   = 1'b0;
            wdat_d  = bus.req_wdata;
          end else begin
            state_d = RD;
            nrd_d   = 1'b0;
          end
        end
      end
      RD: if (req_q.write) begin
        state_d = WR;
        nwr_d   = 1'b0;
        wdat_d  = merge_w;
      end else begin
        state_d = RSP;
        vld_d   = 1'b1;
        rdat_d  = load_w;
      end
      WR: begin
        state_d = RSP;
        vld_d   = 1'b1;
      end
      ERR: begin
        state_d = RSP;
        vld_d   = 1'b1;
        err_d   = 1'b1;
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      nrd_q   <= nrd_d;
      nwr_q   <= nwr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = vld_q;
  assign bus.rsp_rdata    = rdat_q;
  assign bus.rsp_err      = err_q;
  assign bus.MemAddr      = addr_q;
  assign bus.MemWriteData = wdat_q;
  assign bus.mem_nRD      = nrd_q;
  assign bus.mem_nWR      = nwr_q;

`ifdef MAU_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                               err_cnt_q <= '0;
    else if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: byte-array memory model + per-cycle bus checker.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int MEM_BYTES = 64;
  localparam int ADDR_W    = 32;
  localparam logic [31:0] RAM_INIT [16] = '{
    32'h00000000, 32'h00000000, 32'h11223344, 32'hCAFEF00D,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h80017FFE};

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef MAU_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
`ifdef MAU_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  // Bench-side RAM: combinational read, write on the falling edge.
  logic [31:0] ram [16] = RAM_INIT;
  assign bus.MemDataIn = (bus.MemAddr < 32'(MEM_BYTES)) ? ram[bus.MemAddr[5:2]] : 32'h0;
  always @(negedge CLK)
    if (!bus.mem_nWR && bus.MemAddr < 32'(MEM_BYTES)) ram[bus.MemAddr[5:2]] <= bus.MemWriteData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  gm [64];
  bit          gm_ok    = 1'b0;
  bit          acc_next = 1'b0;
  bit          busy     = 1'b0;
  int          lat, nrd_n, nwr_n;
  logic        p_write, p_sgn;
  logic [1:0]  p_size;
  logic [31:0] p_addr, p_wdata;
  logic        e_err;
  logic [31:0] e_rdata, e_base, e_wword;
  int          e_lat, e_nrd, e_nwr;

  task automatic model_accept();
    int          nb;
    logic [63:0] v;
    nb      = (p_size == 2'd0) ? 1 : (p_size == 2'd1) ? 2 : 4;
    e_base  = p_addr - (p_addr % 4);
    e_err   = (p_size == 2'd3) || (p_addr % nb != 0) ||
              (longint'(e_base) + 3 >= longint'(MEM_BYTES));
    e_rdata = 32'h0;
    e_nrd   = 0;
    e_nwr   = 0;
    e_lat   = 2;
    v       = 64'h0;
    if (!e_err) begin
      if (!p_write) begin
        for (int i = 0; i < nb; i++) v = (v << 8) | 64'(gm[p_addr + i]);
        if (p_sgn && v[8*nb-1]) v = v - (64'd1 << (8*nb));
        e_rdata = v[31:0];
        e_nrd   = 1;
      end else begin
        for (int i = 0; i < nb; i++) gm[p_addr + i] = 8'(p_wdata >> (8*(nb-1-i)));
        e_nwr = 1;
        e_nrd = (nb < 4) ? 1 : 0;
        e_lat = (nb < 4) ? 3 : 2;
      end
      e_wword = {gm[e_base], gm[e_base+1], gm[e_base+2], gm[e_base+3]};
    end
  endtask

  // Per-cycle checker, sampling mid-cycle.
  always @(negedge CLK) begin
    if (!gm_ok) begin
      for (int i = 0; i < 64; i++) gm[i] = 8'(RAM_INIT[i/4] >> (8*(3 - i%4)));
      gm_ok = 1'b1;
    end
    if (Reset) begin
      busy     = 1'b0;
      acc_next = 1'b0;
      chk("rst_nRD", bus.mem_nRD, 1);
      chk("rst_nWR", bus.mem_nWR, 1);
    end else begin
      if (acc_next) begin
        busy  = 1'b1;
        lat   = 0;
        nrd_n = 0;
        nwr_n = 0;
        model_accept();
      end
      if (busy) lat++;
      chk("req_ready", bus.req_ready, !busy);
      chk("enables_exclusive", !bus.mem_nRD && !bus.mem_nWR, 0);
      if (!bus.mem_nRD) begin
        nrd_n++;
        chk("rd_in_txn", busy, 1);
        chk("rd_addr", bus.MemAddr, e_base);
      end
      if (!bus.mem_nWR) begin
        nwr_n++;
        chk("wr_in_txn", busy, 1);
        chk("wr_addr", bus.MemAddr, e_base);
        chk("wr_data", bus.MemWriteData, e_wword);
      end
      if (bus.rsp_valid) begin
        chk("rsp_in_txn", busy, 1);
        if (busy) begin
          chk("rsp_rdata", bus.rsp_rdata, e_rdata);
          chk("rsp_err", bus.rsp_err, e_err);
          chk("rsp_latency", lat, e_lat);
          chk("rd_cycles", nrd_n, e_nrd);
          chk("wr_cycles", nwr_n, e_nwr);
          if (p_write && !e_err) chk("ram_word", ram[e_base[5:2]], e_wword);
          busy = 1'b0;
        end
      end
      acc_next = bus.req_valid && bus.req_ready;
      if (acc_next) begin
        p_write = bus.req_write;
        p_size  = bus.req_size;
        p_sgn   = bus.req_signed;
        p_addr  = bus.req_addr;
        p_wdata = bus.req_wdata;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int n);
    @(posedge CLK); #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    rd = 32'h0;
    er = 1'b0;
    n  = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (bus.rsp_valid) begin
        n  = i;
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic run(input string name, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] x_rd, input logic x_er, input int x_lat);
    logic [31:0] rd;
    logic        er;
    int          n;
    do_req(w, sz, sg, a, wd, rd, er, n);
    chk({name, "_rdata"}, rd, x_rd);
    chk({name, "_err"}, er, x_er);
    chk({name, "_lat"}, n, x_lat);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    #12;
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_MemAddr", bus.MemAddr, 32'h0);
    chk("reset_MemWriteData", bus.MemWriteData, 32'h0);
    chk("reset_mem_nRD", bus.mem_nRD, 1);
    chk("reset_mem_nWR", bus.mem_nWR, 1);
`ifdef MAU_ERR_COUNT_EN
    chk("reset_err_count", err_count, 32'h0);
`endif
    @(posedge CLK); #1 Reset = 1'b0;

    // write, size, signed, addr, wdata, exp rdata, exp err, exp latency
    run("sb_5A_at9",     1, SZ_BYTE, 0, 32'd9,  32'h0000005A, 32'h0, 0, 3);
    chk("sb_merged_word", ram[2], 32'h115A3344);
    run("sw_DEADBEEF",   1, SZ_WORD, 0, 32'd8,  32'hDEADBEEF, 32'h0, 0, 2);
    run("lw_8",          0, SZ_WORD, 0, 32'd8,  32'h0,        32'hDEADBEEF, 0, 2);
    run("sw_F0",         1, SZ_WORD, 0, 32'd8,  32'h000000F0, 32'h0, 0, 2);
    run("lb_s_11",       0, SZ_BYTE, 1, 32'd11, 32'h0,        32'hFFFFFFF0, 0, 2);
    run("lb_u_11",       0, SZ_BYTE, 0, 32'd11, 32'h0,        32'h000000F0, 0, 2);
    run("sh_ABCD_at10",  1, SZ_HALF, 0, 32'd10, 32'h1234ABCD, 32'h0, 0, 3);
    chk("sh_merged_word", ram[2], 32'h0000ABCD);
    run("lh_s_10",       0, SZ_HALF, 1, 32'd10, 32'h0,        32'hFFFFABCD, 0, 2);
    run("lh_u_8",        0, SZ_HALF, 0, 32'd8,  32'h0,        32'h00000000, 0, 2);
    run("lb_s_63",       0, SZ_BYTE, 1, 32'd63, 32'h0,        32'hFFFFFFFE, 0, 2);
    run("lh_u_62",       0, SZ_HALF, 0, 32'd62, 32'h0,        32'h00007FFE, 0, 2);
    run("lb_s_60",       0, SZ_BYTE, 1, 32'd60, 32'h0,        32'hFFFFFF80, 0, 2);
    run("lw_60",         0, SZ_WORD, 1, 32'd60, 32'h0,        32'h80017FFE, 0, 2);

    run("err_lh_5",      0, SZ_HALF, 0, 32'd5,  32'h0, 32'h0, 1, 2);
    run("err_lw_62",     0, SZ_WORD, 0, 32'd62, 32'h0, 32'h0, 1, 2);
    run("err_lb_64",     0, SZ_BYTE, 0, 32'd64, 32'h0, 32'h0, 1, 2);
`ifdef MAU_ERR_COUNT_EN
    chk("err_count_3", err_count, 32'd3);
`endif
    run("err_size3",     0, 2'b11,   0, 32'd0,  32'h0, 32'h0, 1, 2);
    run("err_sb_100",    1, SZ_BYTE, 0, 32'd100, 32'hFF, 32'h0, 1, 2);
`ifdef MAU_ERR_COUNT_EN
    chk("err_count_5", err_count, 32'd5);
`endif

    // Abort a word store with Reset before the falling edge of WR.
    @(posedge CLK); #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = SZ_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd12;
    bus.req_wdata  = 32'hCAFEBABE;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    chk("abort_wr_active", bus.mem_nWR, 0);
    #1 Reset = 1'b1;
    #1;
    chk("abort_nWR_async", bus.mem_nWR, 1);
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    @(posedge CLK);
    @(posedge CLK); #1 Reset = 1'b0;
    chk("abort_ram_kept", ram[3], 32'hCAFEF00D);
`ifdef MAU_ERR_COUNT_EN
    chk("abort_err_count", err_count, 32'h0);
`endif
    repeat (4) begin
      @(negedge CLK);
      chk("abort_no_rsp", bus.rsp_valid, 0);
    end
    run("lw_12_after",   0, SZ_WORD, 0, 32'd12, 32'h0, 32'hCAFEF00D, 0, 2);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the active-low data-memory bus: the load/store unit between the CPU datapath and the byte-addressed big-endian data RAM.
- Accepts load/store requests of byte, halfword or word size and drives MemAddr, MemWriteData, mem_nRD and mem_nWR.
- Samples read data combinationally returned by the RAM; the RAM commits writes on the falling CLK edge.
- Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.

Parameters:
- MEM_BYTES, 64, RAM size in bytes; any access with aligned word base + 3 >= MEM_BYTES is an error.
- ADDR_W, 32, address width.

Ports:
- CLK  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal size; valid with rsp_valid.
- MemAddr  out  ADDR_W  word-aligned RAM address.
- MemWriteData  out  32  word to RAM.
- mem_nRD  out  1  active-low read enable.
- mem_nWR  out  1  active-low write enable.
- MemDataIn  in  32  RAM read word.

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-high, Reset.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, MemAddr=0, MemWriteData=0, mem_nRD=1, mem_nWR=1. All outputs except req_ready are registered.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready. The request is captured and req_ready drops the next cycle. There is no response backpressure.
- Base address is req_addr with bits [1:0] cleared; offset is req_addr[1:0].
- Byte lanes are big-endian: offset 0 maps to [31:24] and offset 3 to [7:0]. Halfword offset 0 maps to [31:16] and offset 2 to [15:0].
- Error check at accept: illegal size, half with addr[0]=1, word with addr[1:0]≠0, or base+3 >= MEM_BYTES.
  - Error path: ERR then RSP with rsp_err=1; mem_nRD and mem_nWR never assert.
- FSM states: IDLE, RD, WR, ERR, RSP.
- Load: IDLE→RD→RSP.
  - RD: mem_nRD=0, MemAddr=base; MemDataIn is captured at the end of RD.
  - RSP: rsp_valid=1 and rsp_rdata holds the extracted lane, extended according to req_signed.
  - Latency: accept at edge k, rsp_valid high in cycle k+2.
- Word store: IDLE→WR→RSP.
  - WR: mem_nWR=0 for exactly one full cycle with MemWriteData=req_wdata.
  - Latency: 2 cycles.
- Sub-word store: IDLE→RD→WR→RSP.
  - The read word is merged with req_wdata low bits in the addressed lane only; all other lanes are unchanged.
  - Latency: 3 cycles.
- mem_nRD and mem_nWR are never low in the same cycle. MemAddr and MemWriteData are stable for the whole cycle in which an enable is low.
- RSP always returns to IDLE. req_ready is high in the same cycle as rsp_valid is deasserted, so back-to-back requests run at one request per latency+1 cycles.
- Reset mid-operation: all enables return to 1 immediately and asynchronously, and the FSM goes to IDLE. A write is lost if Reset rises before the falling CLK edge of WR. No response is issued for the aborted request.

Optional Feature:
- MAU_ERR_COUNT_EN defined: adds output err_count[15:0]. It resets to 0 and increments once per rsp_err pulse, saturating at 16'hFFFF.
- Not defined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package mau_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum {IDLE, RD, WR, ERR, RSP};
  - lane-select constants.
- Sub-module mau_lane_align: purely combinational load extraction/extension and store merge, given offset, size, signed flag, read word and store data.

Test Plan:
- Word store 32'hDEADBEEF at addr 8, then word load at addr 8 → mem_nWR low 1 cycle with MemAddr=8; load rsp_rdata=32'hDEADBEEF, rsp_err=0, rsp_valid at k+2.
- Byte store 8'h5A at addr 9 over word 32'h11223344 at 8 → RD then WR with MemWriteData=32'h115A3344; rsp_valid at k+3.
- Byte load addr 11 from word 32'h000000F0 → signed: 32'hFFFFFFF0; unsigned: 32'h000000F0.
- Half load at addr 5, and word load at addr 62 with MEM_BYTES=64 → rsp_err=1, rsp_rdata=0, mem_nRD and mem_nWR remain 1 throughout.
- Reset asserted during WR before the falling edge → mem_nWR=1 asynchronously, RAM word unchanged, req_ready=1, no rsp_valid.
- With MAU_ERR_COUNT_EN: three error requests → err_count=3; Reset → err_count=0.
